// File: rtl/pipe_flow_ctrl.sv
// Flow controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// It applies hazard-unit stall and flush requests to the fetch PC and the stage valids, and keeps statistics.
module pipe_flow_ctrl #(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              STALL_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            haz_stall,
    input  logic            haz_flush,
    input  logic [PC_W-1:0] br_target,
    output logic [PC_W-1:0] pc,
    output logic [4:0]      vld,
    output logic            if_id_we,
    output logic [1:0]      state_o,
    output logic [7:0]      bubble_cnt,
    output logic [7:0]      flush_cnt,
    output logic            stall_to,
    output logic            retire
);

    localparam int SR_W = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [SR_W-1:0] SR_MAX = SR_W'(STALL_MAX);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [4:0]      vld_q, vld_d;
    logic [7:0]      bubble_cnt_q, bubble_cnt_d;
    logic [7:0]      flush_cnt_q, flush_cnt_d;
    logic            stall_to_q, stall_to_d;
    logic [SR_W-1:0] stall_run_q, stall_run_d;

    // Priority: flush beats stall beats advance; exactly one action per cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        vld_d        = vld_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        stall_to_d   = stall_to_q;
        stall_run_d  = stall_run_q;
        if (haz_flush) begin
            pc_d        = br_target;
            vld_d       = {vld_q[3], vld_q[2], 3'b000};
            flush_cnt_d = (flush_cnt_q == 8'hFF) ? flush_cnt_q : flush_cnt_q + 8'd1;
            state_d     = ST_FLUSH;
            stall_run_d = '0;
        end else if (haz_stall) begin
            // IF/ID frozen; a bubble enters EX while older stages drain.
            vld_d        = {vld_q[3], vld_q[2], 1'b0, vld_q[1:0]};
            bubble_cnt_d = (bubble_cnt_q == 8'hFF) ? bubble_cnt_q : bubble_cnt_q + 8'd1;
            state_d      = ST_STALL;
            if (stall_run_q == SR_MAX) begin
                stall_to_d = 1'b1;
            end else begin
                stall_run_d = stall_run_q + 1'b1;
            end
        end else begin
            vld_d       = {vld_q[3:0], fetch_en};
            pc_d        = fetch_en ? pc_q + 1'b1 : pc_q;
            state_d     = ST_RUN;
            stall_run_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            vld_q        <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
            stall_to_q   <= 1'b0;
            stall_run_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            vld_q        <= vld_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            stall_to_q   <= stall_to_d;
            stall_run_q  <= stall_run_d;
        end
    end

    assign if_id_we   = ~haz_stall & ~haz_flush;
    assign pc         = pc_q;
    assign vld        = vld_q;
    assign state_o    = state_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign stall_to   = stall_to_q;
    assign retire     = vld_q[4];

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl: vector table for the main flow, hand sequences for timeout,
// wrap, saturation and reset corner cases.
module tb_pipe_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst, fetch_en, haz_stall, haz_flush;
    logic [7:0] br_target;
    logic [7:0] pc;
    logic [4:0] vld;
    logic       if_id_we;
    logic [1:0] state_o;
    logic [7:0] bubble_cnt, flush_cnt;
    logic       stall_to, retire;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_flow_ctrl #(.PC_W(8), .RESET_PC(8'h00), .STALL_MAX(15)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .haz_stall(haz_stall),
        .haz_flush(haz_flush), .br_target(br_target), .pc(pc), .vld(vld),
        .if_id_we(if_id_we), .state_o(state_o), .bubble_cnt(bubble_cnt),
        .flush_cnt(flush_cnt), .stall_to(stall_to), .retire(retire)
    );

    typedef struct packed {
        logic       rst, fe, st, fl;
        logic [7:0] br;
        logic [7:0] pc;
        logic [4:0] vld;
        logic [1:0] state;
        logic [7:0] bub, fcnt;
        logic       to, we;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic r, input logic fe, input logic st, input logic fl,
                                input logic [7:0] br, input logic [7:0] epc, input logic [4:0] ev,
                                input logic [1:0] es, input logic [7:0] eb, input logic [7:0] ef,
                                input logic eto, input logic ewe);
        vec_t v;
        v.rst = r; v.fe = fe; v.st = st; v.fl = fl; v.br = br;
        v.pc = epc; v.vld = ev; v.state = es; v.bub = eb; v.fcnt = ef; v.to = eto; v.we = ewe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fe, input logic st, input logic fl,
                         input logic [7:0] br);
        rst = r; fetch_en = fe; haz_stall = st; haz_flush = fl; br_target = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] epc, input logic [4:0] ev,
                           input logic [1:0] es, input logic [7:0] eb, input logic [7:0] ef,
                           input logic eto);
        chk({tag, ".pc"}, 32'(pc), 32'(epc));
        chk({tag, ".vld"}, 32'(vld), 32'(ev));
        chk({tag, ".state"}, 32'(state_o), 32'(es));
        chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(eb));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(ef));
        chk({tag, ".stall_to"}, 32'(stall_to), 32'(eto));
        chk({tag, ".retire"}, 32'(retire), 32'(ev[4]));
    endtask

    initial begin
        int exp_bub;

        //              rst fe st fl br     pc     vld     st  bub    fcnt  to we
        vecs[0]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 5'h00, 2'd0, 8'd0, 8'd0, 0, 1);
        vecs[1]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 5'h00, 2'd0, 8'd0, 8'd0, 0, 1);
        vecs[2]  = mk(0, 1, 0, 0, 8'h00, 8'h01, 5'h01, 2'd0, 8'd0, 8'd0, 0, 1);
        vecs[3]  = mk(0, 1, 0, 0, 8'h00, 8'h02, 5'h03, 2'd0, 8'd0, 8'd0, 0, 1);
        vecs[4]  = mk(0, 1, 0, 0, 8'h00, 8'h03, 5'h07, 2'd0, 8'd0, 8'd0, 0, 1);
        vecs[5]  = mk(0, 1, 0, 0, 8'h00, 8'h04, 5'h0F, 2'd0, 8'd0, 8'd0, 0, 1);
        vecs[6]  = mk(0, 1, 0, 0, 8'h00, 8'h05, 5'h1F, 2'd0, 8'd0, 8'd0, 0, 1);
        vecs[7]  = mk(0, 1, 0, 0, 8'h00, 8'h06, 5'h1F, 2'd0, 8'd0, 8'd0, 0, 1);
        vecs[8]  = mk(0, 1, 1, 0, 8'h00, 8'h06, 5'h1B, 2'd1, 8'd1, 8'd0, 0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 8'h00, 8'h06, 5'h13, 2'd1, 8'd2, 8'd0, 0, 0);
        vecs[10] = mk(0, 1, 1, 0, 8'h00, 8'h06, 5'h03, 2'd1, 8'd3, 8'd0, 0, 0);
        vecs[11] = mk(0, 1, 0, 1, 8'h40, 8'h40, 5'h00, 2'd2, 8'd3, 8'd1, 0, 0);
        vecs[12] = mk(0, 1, 0, 0, 8'h00, 8'h41, 5'h01, 2'd0, 8'd3, 8'd1, 0, 1);
        vecs[13] = mk(0, 1, 1, 1, 8'h80, 8'h80, 5'h00, 2'd2, 8'd3, 8'd2, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 8'h00, 8'h80, 5'h00, 2'd0, 8'd3, 8'd2, 0, 1);
        vecs[15] = mk(0, 1, 0, 0, 8'h00, 8'h81, 5'h01, 2'd0, 8'd3, 8'd2, 0, 1);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].fe, vecs[i].st, vecs[i].fl, vecs[i].br);
            #1;
            if (i > 0) chk($sformatf("v%0d.if_id_we", i), 32'(if_id_we), 32'(vecs[i].we));
            tick();
            chk_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].vld, vecs[i].state,
                    vecs[i].bub, vecs[i].fcnt, vecs[i].to);
            $display("vec %0d: rst=%0d fe=%0d st=%0d fl=%0d -> pc=%0h vld=%0h state=%0d bub=%0d fcnt=%0d to=%0d",
                     i, vecs[i].rst, vecs[i].fe, vecs[i].st, vecs[i].fl, pc, vld, state_o,
                     bubble_cnt, flush_cnt, stall_to);
        end

        // Timeout: stall_to rises only after the 16th consecutive stall edge.
        exp_bub = 3;
        for (int i = 1; i <= 16; i++) begin
            drive(0, 1, 1, 0, 8'h00);
            tick();
            exp_bub++;
            chk($sformatf("to_run%0d.stall_to", i), 32'(stall_to), 32'(i == 16));
            chk($sformatf("to_run%0d.pc", i), 32'(pc), 32'h81);
        end
        chk("to.bubble_cnt", 32'(bubble_cnt), 32'(exp_bub));
        $display("timeout run: stall_to=%0d bubble_cnt=%0d", stall_to, bubble_cnt);
        drive(0, 0, 0, 0, 8'h00);
        tick();
        chk("to_release.stall_to", 32'(stall_to), 32'd1);
        chk("to_release.state", 32'(state_o), 32'd0);
        drive(0, 0, 1, 0, 8'h00);
        tick();
        chk("to_after.state", 32'(state_o), 32'd1);
        chk("to_after.bubble_cnt", 32'(bubble_cnt), 32'(exp_bub + 1));
        drive(1, 0, 0, 0, 8'h00);
        tick();
        chk_all("to_rst", 8'h00, 5'h00, 2'd0, 8'd0, 8'd0, 1'b0);
        $display("timeout reset: stall_to=%0d", stall_to);

        // A flush clears the stall run: 15 + flush + 15 stalls stays clear, one more trips it.
        for (int i = 0; i < 15; i++) begin drive(0, 0, 1, 0, 8'h00); tick(); end
        drive(0, 0, 0, 1, 8'h10); tick();
        for (int i = 0; i < 15; i++) begin drive(0, 0, 1, 0, 8'h00); tick(); end
        chk("run_clear.stall_to", 32'(stall_to), 32'd0);
        drive(0, 0, 1, 0, 8'h00); tick();
        chk("run_trip.stall_to", 32'(stall_to), 32'd1);
        chk("run_trip.bubble_cnt", 32'(bubble_cnt), 32'd31);
        $display("run clear: stall_to=%0d bubble_cnt=%0d", stall_to, bubble_cnt);
        drive(1, 0, 0, 0, 8'h00); tick();

        // PC wrap.
        drive(0, 0, 0, 1, 8'hFF); tick();
        chk("wrap_pre.pc", 32'(pc), 32'hFF);
        drive(0, 1, 0, 0, 8'h00); tick();
        chk("wrap.pc", 32'(pc), 32'h00);
        chk("wrap.vld", 32'(vld), 32'h01);
        $display("wrap: pc=%0h vld=%0h", pc, vld);

        // Bubble saturation, then reset in the middle of the stall.
        drive(1, 0, 0, 0, 8'h00); tick();
        for (int i = 1; i <= 300; i++) begin
            drive(0, 1, 1, 0, 8'h00);
            tick();
            if (i == 254 || i == 255 || i == 300)
                chk($sformatf("sat%0d.bubble_cnt", i), 32'(bubble_cnt), 32'((i > 255) ? 255 : i));
        end
        chk("sat.pc", 32'(pc), 32'h00);
        $display("bubble saturation: bubble_cnt=%0d", bubble_cnt);
        drive(1, 1, 1, 0, 8'h00); tick();
        chk_all("rst_mid_stall", 8'h00, 5'h00, 2'd0, 8'd0, 8'd0, 1'b0);

        // Flush saturation, then reset in the middle of a flush.
        for (int i = 1; i <= 260; i++) begin
            drive(0, 1, 0, 1, 8'(i));
            tick();
            if (i == 255 || i == 260)
                chk($sformatf("fsat%0d.flush_cnt", i), 32'(flush_cnt), 32'd255);
        end
        chk("fsat.pc", 32'(pc), 32'(8'(260)));
        chk("fsat.state", 32'(state_o), 32'd2);
        $display("flush saturation: flush_cnt=%0d", flush_cnt);
        drive(1, 1, 0, 1, 8'h55); tick();
        chk_all("rst_mid_flush", 8'h00, 5'h00, 2'd0, 8'd0, 8'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Pipeline flow controller that consumes the stall and flush decisions produced by `tt_um_combo_haz`, the hazard-priority unit. It owns the fetch PC and the per-stage valid tokens of a 5-stage IF/ID/EX/MEM/WB pipeline. It applies stalls by freezing IF/ID and injecting EX bubbles, and applies flushes by killing younger stages and redirecting the PC. It also keeps saturating bubble and flush statistics and a sticky stall-timeout error flag.

## Interface
- `PC_W`, 8: PC width in bits.
- `RESET_PC`, 0: PC value loaded on reset.
- `STALL_MAX`, 15: largest allowed number of consecutive stall cycles. The stall-run counter width is `$clog2(STALL_MAX+1)`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  fetch permitted this cycle.
- `haz_stall`  in  1  stall request from the hazard unit (data or structural).
- `haz_flush`  in  1  flush request from the hazard unit (control mispredict, resolved in EX).
- `br_target`  in  PC_W  redirect PC, sampled when `haz_flush`=1.
- `pc`  out  PC_W  current fetch PC (registered).
- `vld`  out  5  stage valids, registered; bit0=IF, bit1=ID, bit2=EX, bit3=MEM, bit4=WB.
- `if_id_we`  out  1  combinational; 1 when IF/ID advances this cycle, i.e. no stall action and no flush action.
- `state_o`  out  2  FSM state: RUN=0, STALL=1, FLUSH=2.
- `bubble_cnt`  out  8  saturating count of injected EX bubbles.
- `flush_cnt`  out  8  saturating count of accepted flushes.
- `stall_to`  out  1  sticky; set when a stall exceeds `STALL_MAX` cycles.
- `retire`  out  1  equals `vld[4]`.

## Operation
Each cycle performs exactly one action, chosen by priority: flush > stall > advance.

**Flush** (`haz_flush`=1, in any state):
- `pc` <= `br_target`.
- `vld[0]`, `vld[1]`, `vld[2]` <= 0.
- `vld[3]` <= `vld[2]`; `vld[4]` <= `vld[3]`.
- `flush_cnt`++, saturating at 255.
- Next state FLUSH.
- Stall-run counter cleared.

**Stall** (`haz_stall`=1, `haz_flush`=0):
- `pc`, `vld[0]`, `vld[1]` hold.
- `vld[2]` <= 0 (bubble).
- `vld[3]` <= `vld[2]`; `vld[4]` <= `vld[3]`.
- `bubble_cnt`++, saturating at 255.
- Next state STALL.
- Stall-run counter increments. If the counter already equals `STALL_MAX`, `stall_to` <= 1 and the counter holds.

**Advance** (neither request):
- `vld[0]` <= `fetch_en`; `vld[n]` <= `vld[n-1]` for n=1..4.
- If `fetch_en`, `pc` <= `pc`+1, wrapping modulo 2^PC_W. Otherwise `pc` holds.
- Next state RUN.
- Stall-run counter cleared.

FSM rules:
- The next state depends only on the current-cycle requests. RUN, STALL and FLUSH share identical transition rules.
- FLUSH therefore lasts one cycle unless `haz_flush` repeats. In that cycle IF refetches from the new `pc`.

Other rules:
- `stall_to` is cleared only by `rst`. It does not alter the datapath: stalls continue to be honoured after timeout.
- `fetch_en`=0 during a stall or flush has no extra effect.

## Timing
- Reset values (applied on the edge where `rst`=1, overriding all inputs):
  - `pc`=RESET_PC, `vld`=0, `state_o`=RUN.
  - `bubble_cnt`=0, `flush_cnt`=0, `stall_to`=0, stall-run counter 0.
- Latencies:
  - Request inputs take effect on the next rising edge; outputs change one cycle later.
  - `if_id_we` reflects the current-cycle inputs (zero latency).
  - An instruction fetched at edge k (`vld[0]`=1 after k) reaches `retire` after edge k+4 if there are no stalls. Each stall cycle adds one cycle.
- Simultaneous `haz_stall`=1 and `haz_flush`=1: the flush is applied, no bubble is counted, and the stall-run counter clears.
- `rst` asserted mid-stall or mid-flush: the reset values apply on that edge; no counter update occurs.
- `pc` wraps from 2^PC_W-1 to 0 on an advance with `fetch_en`=1.
- Both 8-bit counters hold at 255.

## Test plan
- **Reset then run:** `rst`=1 for 2 cycles, then `fetch_en`=1 for 6 cycles -> `pc` steps 0,1,…,6; `vld` fills 0x01,0x03,…,0x1F; `retire`=1 from cycle 5.
- **Stall:** with `vld`=0x1F, `pc`=6, hold `haz_stall`=1 for 3 cycles -> `pc` stays 6; `vld` goes 0x1B, 0x13, 0x03; `bubble_cnt`=3; `state_o`=1; `if_id_we`=0 throughout.
- **Flush:** `haz_flush`=1 with `br_target`=0x40 for 1 cycle -> `pc`=0x40; `vld[2:0]`=0; `flush_cnt`=1; `state_o`=2. Next cycle `pc`=0x41, `vld[0]`=1, `state_o`=0.
- **Simultaneous requests:** `haz_stall`=1 and `haz_flush`=1 together -> flush behaviour only; `bubble_cnt` unchanged; `flush_cnt`+1.
- **Timeout:** `STALL_MAX`=15; hold `haz_stall` for 16 cycles -> `stall_to` rises after the 16th edge. Release the stall -> `stall_to` stays 1 and `state_o`=0. `rst` -> `stall_to`=0.
- **Wrap and saturation:** with `pc`=0xFF, advance with `fetch_en`=1 -> `pc`=0x00. Apply 300 stall cycles -> `bubble_cnt`=255. Assert `rst` mid-stall -> all outputs return to their reset values.
